// File: rtl/clock_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_multi
// Brief    : NUM_CH independent programmable clock dividers with tick strobes.
// Revision : 1.0
// ============================================================================
module clock_div_multi #(
  parameter int          NUM_CH         = 2,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 125000000,
  parameter int unsigned DEFAULT_HIGH   = 62500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_high,
  output logic [NUM_CH-1:0]       clk_div,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  localparam logic [CNT_W-1:0] c_DEF_PER  = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] c_DEF_HIGH = CNT_W'(DEFAULT_HIGH);
  localparam logic [CNT_W-1:0] c_MIN_PER  = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] w_raw_per;
    logic [CNT_W-1:0] w_req_per;
    logic [CNT_W-1:0] w_req_high;
    logic [CNT_W-1:0] w_last;
    logic             w_wrap;
    logic             w_apply;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_pend_per;
    logic [CNT_W-1:0] r_pend_high;
    logic             r_busy;
    logic             r_clk_div;
    logic             r_tick;

    assign w_raw_per  = cfg_period[gi*CNT_W +: CNT_W];
    assign w_req_per  = (w_raw_per < c_MIN_PER) ? c_MIN_PER : w_raw_per;
    assign w_req_high = cfg_high[gi*CNT_W +: CNT_W];
    assign w_last     = r_per - c_ONE;
    assign w_wrap     = en[gi] && (r_cnt == w_last);
    // New settings only take effect at a period boundary or while stopped.
    assign w_apply    = w_wrap || !en[gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt       <= '0;
        r_per       <= c_DEF_PER;
        r_high      <= c_DEF_HIGH;
        r_pend_per  <= c_DEF_PER;
        r_pend_high <= c_DEF_HIGH;
        r_busy      <= 1'b0;
        r_clk_div   <= 1'b0;
        r_tick      <= 1'b0;
      end else begin
        if (en[gi]) begin
          r_clk_div <= (r_cnt < r_high);
          r_tick    <= w_wrap;
          r_cnt     <= w_wrap ? '0 : r_cnt + c_ONE;
        end else begin
          r_clk_div <= 1'b0;
          r_tick    <= 1'b0;
          r_cnt     <= '0;
        end

        if (cfg_load[gi]) begin
          r_pend_per  <= w_req_per;
          r_pend_high <= w_req_high;
          if (w_apply) begin
            r_per  <= w_req_per;
            r_high <= w_req_high;
            r_busy <= 1'b0;
          end else begin
            r_busy <= 1'b1;
          end
        end else if (w_apply) begin
          r_per  <= r_pend_per;
          r_high <= r_pend_high;
          r_busy <= 1'b0;
        end
      end
    end

    assign clk_div[gi] = r_clk_div;
    assign tick[gi]    = r_tick;
    assign busy[gi]    = r_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_div_multi
// Brief    : Directed self-checking bench for clock_div_multi (2 ch, 8-bit).
// Revision : 1.0
// ============================================================================
module tb_clock_div_multi;

  localparam int NCH = 2;
  localparam int CW  = 8;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    cfg_load;
  logic [NCH*CW-1:0] cfg_period;
  logic [NCH*CW-1:0] cfg_high;
  logic [NCH-1:0]    clk_div;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    busy;

  int n_cmp;
  int n_err;

  clock_div_multi #(
    .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_PERIOD(8), .DEFAULT_HIGH(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
    .clk_div(clk_div), .tick(tick), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int p, input int h);
    cfg_period[ch*CW +: CW] = CW'(p);
    cfg_high[ch*CW +: CW]   = CW'(h);
  endtask

  // Load channel 0 while it is stopped so the values apply at once.
  task automatic load_stopped0(input int p, input int h);
    en[0] = 1'b0;
    set_cfg(0, p, h);
    cfg_load = 2'b01;
    step();
    cfg_load = 2'b00;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++;
    if (clk_div !== 2'b00) begin n_err++; $display("FAIL reset_clk_div: got %b expected 00", clk_div); end
    n_cmp++;
    if (tick !== 2'b00) begin n_err++; $display("FAIL reset_tick: got %b expected 00", tick); end
    n_cmp++;
    if (busy !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %b expected 00", busy); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic ec, et;
    load_stopped0(10, 3);
    n_cmp++;
    if (busy[0] !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b expected 0", busy[0]); end
    en[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      ec = (((k-1) % 10) < 3);
      et = (((k-1) % 10) == 9);
      n_cmp++;
      if (clk_div[0] !== ec) begin n_err++; $display("FAIL basic_clk k=%0d: got %b expected %b", k, clk_div[0], ec); end
      n_cmp++;
      if (tick[0] !== et) begin n_err++; $display("FAIL basic_tick k=%0d: got %b expected %b", k, tick[0], et); end
      n_cmp++;
      if (clk_div[1] !== 1'b0) begin n_err++; $display("FAIL basic_ch1_idle k=%0d: got %b expected 0", k, clk_div[1]); end
    end
  endtask

  task automatic test_midload();
    logic ec, et;
    en[0] = 1'b0;
    step();
    en[0] = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    set_cfg(0, 7, 7);
    cfg_load = 2'b01;
    step();
    n_cmp++;
    if (busy[0] !== 1'b1) begin n_err++; $display("FAIL mid_busy_first: got %b expected 1", busy[0]); end
    set_cfg(0, 4, 2);
    step();
    cfg_load = 2'b00;
    n_cmp++;
    if (busy[0] !== 1'b1) begin n_err++; $display("FAIL mid_busy_second: got %b expected 1", busy[0]); end
    for (int k = 8; k <= 9; k++) begin
      step();
      n_cmp++;
      if (busy[0] !== 1'b1 || tick[0] !== 1'b0) begin
        n_err++; $display("FAIL mid_hold k=%0d: got busy=%b tick=%b expected busy=1 tick=0", k, busy[0], tick[0]);
      end
    end
    step();
    n_cmp++;
    if (tick[0] !== 1'b1 || busy[0] !== 1'b0 || clk_div[0] !== 1'b0) begin
      n_err++; $display("FAIL mid_wrap: got tick=%b busy=%b clk=%b expected 1 0 0", tick[0], busy[0], clk_div[0]);
    end
    for (int j = 0; j < 8; j++) begin
      step();
      ec = ((j % 4) < 2);
      et = ((j % 4) == 3);
      n_cmp++;
      if (clk_div[0] !== ec || tick[0] !== et || busy[0] !== 1'b0) begin
        n_err++; $display("FAIL mid_new j=%0d: got clk=%b tick=%b busy=%b expected %b %b 0", j, clk_div[0], tick[0], busy[0], ec, et);
      end
    end
  endtask

  task automatic test_clamp();
    int tp [4] = '{0, 1, 4, 5};
    int th [4] = '{1, 1, 0, 12};
    int ep [4] = '{2, 2, 4, 5};
    logic ec, et;
    for (int c = 0; c < 4; c++) begin
      load_stopped0(tp[c], th[c]);
      en[0] = 1'b1;
      for (int k = 1; k <= 2*ep[c]; k++) begin
        step();
        ec = (((k-1) % ep[c]) < th[c]);
        et = (((k-1) % ep[c]) == ep[c]-1);
        n_cmp++;
        if (clk_div[0] !== ec || tick[0] !== et) begin
          n_err++; $display("FAIL clamp c=%0d k=%0d: got clk=%b tick=%b expected %b %b", c, k, clk_div[0], tick[0], ec, et);
        end
      end
    end
  endtask

  task automatic test_max_period();
    int highs, ticks;
    highs = 0;
    ticks = 0;
    load_stopped0(255, 128);
    en[0] = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      step();
      if (clk_div[0] === 1'b1) highs++;
      if (tick[0] === 1'b1) ticks++;
    end
    n_cmp++;
    if (tick[0] !== 1'b1) begin n_err++; $display("FAIL max_last_tick: got %b expected 1", tick[0]); end
    n_cmp++;
    if (highs != 128 || ticks != 1) begin n_err++; $display("FAIL max_counts: got highs=%0d ticks=%0d expected 128 1", highs, ticks); end
    step();
    n_cmp++;
    if (clk_div[0] !== 1'b1 || tick[0] !== 1'b0) begin
      n_err++; $display("FAIL max_restart: got clk=%b tick=%b expected 1 0", clk_div[0], tick[0]);
    end
  endtask

  task automatic test_independent();
    int c1;
    logic ec0, et0, ec1, et1;
    en = 2'b00;
    set_cfg(0, 6, 3);
    set_cfg(1, 9, 4);
    cfg_load = 2'b11;
    step();
    cfg_load = 2'b00;
    en = 2'b11;
    c1 = 0;
    for (int k = 1; k <= 30; k++) begin
      en[1] = !(k >= 10 && k <= 12);
      step();
      ec0 = (((k-1) % 6) < 3);
      et0 = (((k-1) % 6) == 5);
      if (en[1]) begin
        ec1 = (c1 < 4);
        et1 = (c1 == 8);
        c1 = (c1 == 8) ? 0 : c1 + 1;
      end else begin
        ec1 = 1'b0;
        et1 = 1'b0;
        c1 = 0;
      end
      n_cmp++;
      if (clk_div[0] !== ec0 || tick[0] !== et0) begin
        n_err++; $display("FAIL indep_ch0 k=%0d: got clk=%b tick=%b expected %b %b", k, clk_div[0], tick[0], ec0, et0);
      end
      n_cmp++;
      if (clk_div[1] !== ec1 || tick[1] !== et1) begin
        n_err++; $display("FAIL indep_ch1 k=%0d: got clk=%b tick=%b expected %b %b", k, clk_div[1], tick[1], ec1, et1);
      end
    end
    en[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ec, et;
    load_stopped0(10, 8);
    en = 2'b01;
    for (int k = 1; k <= 6; k++) step();
    set_cfg(0, 4, 2);
    cfg_load = 2'b01;
    step();
    cfg_load = 2'b00;
    n_cmp++;
    if (clk_div[0] !== 1'b1 || busy[0] !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: got clk=%b busy=%b expected 1 1", clk_div[0], busy[0]);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (clk_div !== 2'b00 || tick !== 2'b00 || busy !== 2'b00) begin
      n_err++; $display("FAIL rstmid_async: got clk=%b tick=%b busy=%b expected 00 00 00", clk_div, tick, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      ec = (((k-1) % 8) < 4);
      et = (((k-1) % 8) == 7);
      n_cmp++;
      if (clk_div[0] !== ec || tick[0] !== et || busy[0] !== 1'b0) begin
        n_err++; $display("FAIL rstmid_default k=%0d: got clk=%b tick=%b busy=%b expected %b %b 0", k, clk_div[0], tick[0], busy[0], ec, et);
      end
    end
  endtask

  task automatic test_load_on_wrap();
    logic ec, et;
    load_stopped0(5, 2);
    en[0] = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    set_cfg(0, 3, 1);
    cfg_load = 2'b01;
    step();
    cfg_load = 2'b00;
    n_cmp++;
    if (busy[0] !== 1'b0 || tick[0] !== 1'b1) begin
      n_err++; $display("FAIL wrapload_edge: got busy=%b tick=%b expected 0 1", busy[0], tick[0]);
    end
    for (int j = 0; j < 6; j++) begin
      step();
      ec = ((j % 3) < 1);
      et = ((j % 3) == 2);
      n_cmp++;
      if (clk_div[0] !== ec || tick[0] !== et || busy[0] !== 1'b0) begin
        n_err++; $display("FAIL wrapload_new j=%0d: got clk=%b tick=%b busy=%b expected %b %b 0", j, clk_div[0], tick[0], busy[0], ec, et);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    en         = '0;
    cfg_load   = '0;
    cfg_period = '0;
    cfg_high   = '0;
    test_reset();
    test_basic();
    test_midload();
    test_clamp();
    test_max_period();
    test_independent();
    test_reset_mid();
    test_load_on_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- Parametrised, multi-channel successor to the team's fixed 1 Hz divider.
- Each channel generates a divided clock level and a one-cycle tick strobe from the single system clock.
- Each channel has its own runtime-programmable period, high time and enable.
- Feeds display scanning, debounce sampling and LED blink logic in the lab designs.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8)
- CNT_W, 32, counter / period / high-time width in bits
- DEFAULT_PERIOD, 125000000, active period per channel after reset (1 Hz at 125 MHz)
- DEFAULT_HIGH, 62500000, active high time per channel after reset (50 % duty)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  NUM_CH  per-channel run enable
- cfg_load  in  NUM_CH  per-channel one-cycle load strobe
- cfg_period  in  NUM_CH*CNT_W  requested period in clk cycles; channel i at bits [i*CNT_W +: CNT_W]
- cfg_high  in  NUM_CH*CNT_W  requested high time in clk cycles; same packing
- clk_div  out  NUM_CH  divided clock level, registered
- tick  out  NUM_CH  one-cycle strobe on the last cycle of each period, registered
- busy  out  NUM_CH  pending configuration not yet applied

Behaviour:
- Reset (async assert):
  - cnt = 0, clk_div = 0, tick = 0, busy = 0.
  - Active period = DEFAULT_PERIOD; active high = DEFAULT_HIGH.
  - Pending registers = defaults.
- Per-channel state: cnt[CNT_W], active period P, active high H, pending period/high, busy flag.
- Enabled edge (en[i]=1):
  - clk_div[i] <= (cnt < H).
  - tick[i] <= (cnt == P-1).
  - cnt <= (cnt == P-1) ? 0 : cnt+1.
  - Outputs lag cnt by one cycle. Period is exactly P cycles: high for min(H,P) cycles, then low.
- Disabled edge (en[i]=0):
  - cnt <= 0, clk_div <= 0, tick <= 0.
  - Re-enable restarts the period from cnt=0; first enabled edge drives clk_div=1 if H>0.
- Clamping:
  - cfg_period < 2 is stored as 2.
  - cfg_period = 2^CNT_W-1 is legal.
  - H >= P gives a constant-high output. H = 0 gives a constant-low output.
  - tick still pulses once per period in both cases.
- Configuration load (glitch-free):
  - cfg_load[i] captures cfg_period/cfg_high (clamped) into the pending registers and sets busy[i].
  - Pending values are copied to P/H, and busy cleared, on the first edge where the channel wraps (en=1 and cnt==P-1) or en[i]=0.
  - A load and a wrap on the same edge: the new values are captured and applied on that same edge. busy never rises; the next period uses the new values.
  - A second load before apply overwrites pending (last wins); busy stays 1.
  - P and H are never changed mid-period.
- Channels are fully independent. There is no phase relationship between channels unless they are enabled on the same edge with equal P.
- Arithmetic: all compares are unsigned CNT_W-bit; there is no overflow path since cnt < P always.
- Reset asserted mid-period: immediate return to reset values. After release, first edge behaves as the first enabled edge.

Test Plan:
- Reset, then en=1 for channel 0; load P=10, H=3 while disabled, then enable → clk_div high for cycles 1-3, low 4-10, period 10; tick on every 10th output cycle, width 1.
- P=10 running; load P=4, H=2 at cnt=5 → busy=1 until wrap; old period completes 10 cycles, then a 4-cycle period with 2 high; busy drops at the wrap edge.
- Load P=0 and P=1 → both behave as P=2, H=1: output toggles every cycle, tick every 2 cycles. Load H=0 → clk_div stays 0, tick continues. Load H=12 with P=5 → clk_div stays 1.
- Channel 0 at P=6 and channel 1 at P=9 enabled together; toggle en[1] low for 3 cycles → channel 0 is unaffected; channel 1 output is 0 while disabled and restarts with a full 9-cycle period.
- Assert rst at cnt=7 of P=10 → clk_div, tick and busy go 0 asynchronously. After release with en=1, the period is DEFAULT_PERIOD (override to 8/4 in the bench via parameters) and clk_div=1 on the first edge.
- Load coinciding with the wrap edge (P=5→P=3) → no busy pulse; the very next period is 3 cycles.
